decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL use the following ports, one per line as name, direction, width and meaning, with the clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- D_stat  in  2  decode-register status
- D_opcode  in  8  icode[7:4], ifun[3:0]
- D_rArB  in  8  rA[7:4], rB[3:0]
- D_valC  in  64  constant word
- D_valP  in  64  next-PC
- E_bubble  in  1  load a bubble into the E register
- e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  in  4 each  downstream destination IDs
- e_valE, M_valE, m_valM, W_valE, W_valM  in  64 each  matching forward/writeback values
- d_srcA, d_srcB  out  4 each  combinational source IDs, for the hazard unit
- E_stat  out  2  registered status
- E_icode, E_ifun  out  4 each  registered instruction code and function
- E_valC, E_valA, E_valB  out  64 each  registered operands
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered register IDs
REQ-002 Register ID 4'hF SHALL mean "no register"; ID 4 SHALL be %rsp.
REQ-003 Status encoding SHALL be 00 AOK, 01 HLT, 10 ADR, 11 INS.

Function
REQ-004 srcA SHALL be:
- rA for icodes 2, 4, 6 and A;
- 4 for icodes 9 and B;
- otherwise F.
REQ-005 srcB SHALL be:
- rB for icodes 4, 5 and 6;
- 4 for icodes 8, 9, A and B;
- otherwise F.
REQ-006 dstE SHALL be:
- rB for icodes 2, 3 and 6;
- 4 for icodes 8, 9, A and B;
- otherwise F.
REQ-007 dstM SHALL be rA for icodes 5 and B, and F otherwise.
REQ-008 d_valA SHALL be D_valP for icodes 7 and 8; otherwise it SHALL be forwarded for srcA.
REQ-009 Forwarding SHALL apply to srcA and srcB only when the source is not F, with priority:
- e_dstE→e_valE
- M_dstM→m_valM
- M_dstE→M_valE
- W_dstM→W_valM
- W_dstE→W_valE
- register file
REQ-010 The register file SHALL hold 15 registers of 64 bits (IDs 0–E) with two combinational read ports.
REQ-011 The register file SHALL have two write ports, written on the clk edge: W_dstE/W_valE and W_dstM/W_valM.
REQ-012 A write to ID F SHALL be ignored.
REQ-013 When W_dstE equals W_dstM (not F), W_valM SHALL win.
REQ-014 The E register SHALL load all decoded fields on every rising clk edge, giving a latency of one cycle from D inputs to E outputs.
REQ-015 When E_bubble=1 at the edge, the E register SHALL load a bubble:
- stat 00, icode 1, ifun 0;
- valC, valA and valB all 0;
- every register ID F.
REQ-016 When D_stat is not AOK, the decoded fields SHALL still pass through, and E_stat SHALL carry D_stat unchanged.
REQ-017 A same-cycle write and read of one register SHALL be resolved by forwarding (REQ-009), not by the register-file read.

Reset
REQ-018 While reset=1, all 15 registers SHALL be 0 immediately, independent of clk.
REQ-019 While reset=1, the E register SHALL hold the bubble value of REQ-015.
REQ-020 Reset asserted mid-operation SHALL discard any in-flight write in that cycle.
REQ-021 The first edge after reset deasserts SHALL load D inputs normally.

Structure
REQ-022 A shared package y86_pkg SHALL define:
- the icode constants 0–B;
- the stat codes;
- RNONE=4'hF and RRSP=4'h4;
- the bubble field values.
REQ-023 The register file SHALL be a sub-module y86_regfile covering REQ-010 to REQ-013 and REQ-018.
REQ-024 All decode and forwarding logic SHALL be in decode_stage.

Verification
REQ-025 The bench SHALL cover:
- Reset: assert reset asynchronously between edges → E_icode=1 and E_dstE=F immediately; read of reg 3 returns 0.
- Writeback then read: W_dstE=3 with W_valE=0x55 for one edge; then D irmovq-free opq rA=3 → after next edge E_valA=0x55.
- Forward priority: srcA=2 with e_dstE=2/e_valE=0x11 and also M_dstM=2/m_valM=0x22 → d_valA=0x11; drop e_dstE → 0x22.
- Call/pop: D_opcode=0x80 with D_valP=0x100 → E_valA=0x100, E_srcB=4, E_dstE=4; D_opcode=0xB0 with rA=5 → E_srcA=4, E_dstM=5.
- Bubble: E_bubble=1 with a valid opq in D → E_icode=1, E_stat=00, all IDs F; next cycle with E_bubble=0 → the opq appears.
- Dual write: W_dstE=W_dstM=4, W_valE=1, W_valM=2 → reg 4 reads 2.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, register IDs and
// the field values loaded into a pipeline register when it takes a bubble.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'b00;
  localparam logic [1:0] S_HLT = 2'b01;
  localparam logic [1:0] S_ADR = 2'b10;
  localparam logic [1:0] S_INS = 2'b11;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;
  localparam int         NREGS = 15;

  localparam logic [1:0] BUB_STAT  = S_AOK;
  localparam logic [3:0] BUB_ICODE = I_NOP;
  localparam logic [3:0] BUB_IFUN  = 4'h0;

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of every decode-stage signal except clock and reset; the pipeline
// side drives the D register, forwarding buses and bubble control.
interface decode_stage_if;
  logic [1:0]  D_stat;
  logic [7:0]  D_opcode;
  logic [7:0]  D_rArB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;
  logic        E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [1:0]  E_stat;
  logic [3:0]  E_icode, E_ifun;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

  modport master (
    output D_stat, D_opcode, D_rArB, D_valC, D_valP, E_bubble,
           e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
           e_valE, M_valE, m_valM, W_valE, W_valM,
    input  d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB
  );

  modport slave (
    input  D_stat, D_opcode, D_rArB, D_valC, D_valP, E_bubble,
           e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
           e_valE, M_valE, m_valM, W_valE, W_valM,
    output d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_dstE, E_dstM, E_srcA, E_srcB
  );
endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two combinational read ports, two write ports.
// ID F reads as zero and is never written; the M port overrides the E port.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        rd_a_id_i,
  output logic [DATA_W-1:0] rd_a_data_o,
  input  logic [3:0]        rd_b_id_i,
  output logic [DATA_W-1:0] rd_b_data_o,
  input  logic [3:0]        wr_e_id_i,
  input  logic [DATA_W-1:0] wr_e_data_i,
  input  logic [3:0]        wr_m_id_i,
  input  logic [DATA_W-1:0] wr_m_data_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // M write is issued last so it takes precedence when both ports hit one ID
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (wr_e_id_i != RNONE) regs_q[wr_e_id_i] <= wr_e_data_i;
      if (wr_m_id_i != RNONE) regs_q[wr_m_id_i] <= wr_m_data_i;
    end
  end

  assign rd_a_data_o = (rd_a_id_i == RNONE) ? '0 : regs_q[rd_a_id_i];
  assign rd_b_data_o = (rd_b_id_i == RNONE) ? '0 : regs_q[rd_b_id_i];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: register-ID decode, operand forwarding, register file
// and the E pipeline register (bubble-capable).
module decode_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        D_stat,
  input  logic [7:0]        D_opcode,
  input  logic [7:0]        D_rArB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic              E_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [1:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB
);

  logic [3:0]        icode, ifun, ra, rb;
  logic [3:0]        srca, srcb, dste, dstm;
  logic [DATA_W-1:0] rf_a, rf_b, vala, valb;

  assign icode = D_opcode[7:4];
  assign ifun  = D_opcode[3:0];
  assign ra    = D_rArB[7:4];
  assign rb    = D_rArB[3:0];

  // Newest producer wins; a same-cycle writeback is caught here, not by the file
  function automatic logic [DATA_W-1:0] fwd(input logic [3:0]        src,
                                            input logic [DATA_W-1:0] rf_val);
    if (src == RNONE)       return rf_val;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_val;
  endfunction

  always_comb begin
    srca = RNONE;
    srcb = RNONE;
    dste = RNONE;
    dstm = RNONE;
    case (icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srca = ra;
      I_RET, I_POPQ:                      srca = RRSP;
      default:                            srca = RNONE;
    endcase
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          srcb = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     srcb = RRSP;
      default:                            srcb = RNONE;
    endcase
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dste = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     dste = RRSP;
      default:                            dste = RNONE;
    endcase
    if (icode == I_MRMOVQ || icode == I_POPQ) dstm = ra;
  end

  y86_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk         (clk),
    .reset       (reset),
    .rd_a_id_i   (srca),
    .rd_a_data_o (rf_a),
    .rd_b_id_i   (srcb),
    .rd_b_data_o (rf_b),
    .wr_e_id_i   (W_dstE),
    .wr_e_data_i (W_valE),
    .wr_m_id_i   (W_dstM),
    .wr_m_data_i (W_valM)
  );

  assign vala   = (icode == I_JXX || icode == I_CALL) ? D_valP : fwd(srca, rf_a);
  assign valb   = fwd(srcb, rf_b);
  assign d_srcA = srca;
  assign d_srcB = srcb;

  // ---- D -> E pipeline register boundary ----
  logic [1:0]        stat_d, stat_q;
  logic [3:0]        icode_d, icode_q, ifun_d, ifun_q;
  logic [DATA_W-1:0] valc_d, valc_q, vala_d, vala_q, valb_d, valb_q;
  logic [3:0]        dste_d, dste_q, dstm_d, dstm_q, srca_d, srca_q, srcb_d, srcb_q;

  always_comb begin
    stat_d  = D_stat;
    icode_d = icode;
    ifun_d  = ifun;
    valc_d  = D_valC;
    vala_d  = vala;
    valb_d  = valb;
    dste_d  = dste;
    dstm_d  = dstm;
    srca_d  = srca;
    srcb_d  = srcb;
    if (E_bubble) begin
      stat_d  = BUB_STAT;
      icode_d = BUB_ICODE;
      ifun_d  = BUB_IFUN;
      valc_d  = '0;
      vala_d  = '0;
      valb_d  = '0;
      dste_d  = RNONE;
      dstm_d  = RNONE;
      srca_d  = RNONE;
      srcb_d  = RNONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q  <= BUB_STAT;
      icode_q <= BUB_ICODE;
      ifun_q  <= BUB_IFUN;
      valc_q  <= '0;
      vala_q  <= '0;
      valb_q  <= '0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
      srca_q  <= RNONE;
      srcb_q  <= RNONE;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      valc_q  <= valc_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
    end
  end

  assign E_stat  = stat_q;
  assign E_icode = icode_q;
  assign E_ifun  = ifun_q;
  assign E_valC  = valc_q;
  assign E_valA  = vala_q;
  assign E_valB  = valb_q;
  assign E_dstE  = dste_q;
  assign E_dstM  = dstm_q;
  assign E_srcA  = srca_q;
  assign E_srcB  = srcb_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a behavioural model
// built from the decode table, forwarding priority list and a register array.
module tb_decode_stage;

  typedef struct {
    logic [1:0]  stat;
    logic [3:0]  icode, ifun, dstE, dstM, srcA, srcB;
    logic [63:0] valC, valA, valB;
  } e_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [63:0] rf_m [15];
  e_t   ex;

  decode_stage_if dif ();

  decode_stage dut (
    .clk      (clk),
    .reset    (reset),
    .D_stat   (dif.D_stat),
    .D_opcode (dif.D_opcode),
    .D_rArB   (dif.D_rArB),
    .D_valC   (dif.D_valC),
    .D_valP   (dif.D_valP),
    .E_bubble (dif.E_bubble),
    .e_dstE   (dif.e_dstE),
    .M_dstE   (dif.M_dstE),
    .M_dstM   (dif.M_dstM),
    .W_dstE   (dif.W_dstE),
    .W_dstM   (dif.W_dstM),
    .e_valE   (dif.e_valE),
    .M_valE   (dif.M_valE),
    .m_valM   (dif.m_valM),
    .W_valE   (dif.W_valE),
    .W_valM   (dif.W_valM),
    .d_srcA   (dif.d_srcA),
    .d_srcB   (dif.d_srcB),
    .E_stat   (dif.E_stat),
    .E_icode  (dif.E_icode),
    .E_ifun   (dif.E_ifun),
    .E_valC   (dif.E_valC),
    .E_valA   (dif.E_valA),
    .E_valB   (dif.E_valB),
    .E_dstE   (dif.E_dstE),
    .E_dstM   (dif.E_dstM),
    .E_srcA   (dif.E_srcA),
    .E_srcB   (dif.E_srcB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic e_t bubble_val();
    e_t b;
    b.stat = 2'b00; b.icode = 4'h1; b.ifun = 4'h0;
    b.valC = 64'h0; b.valA = 64'h0; b.valB = 64'h0;
    b.dstE = 4'hF;  b.dstM = 4'hF;  b.srcA = 4'hF; b.srcB = 4'hF;
    return b;
  endfunction

  function automatic logic [63:0] fwd_m(input logic [3:0] src);
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    if (src == 4'hF) return 64'h0;
    ids  = '{dif.e_dstE, dif.M_dstM, dif.M_dstE, dif.W_dstM, dif.W_dstE};
    vals = '{dif.e_valE, dif.m_valM, dif.M_valE, dif.W_valM, dif.W_valE};
    for (int k = 0; k < 5; k++)
      if (ids[k] == src) return vals[k];
    return rf_m[src];
  endfunction

  function automatic e_t predict();
    e_t p;
    logic [3:0] ic, ra, rb;
    ic = dif.D_opcode[7:4];
    ra = dif.D_rArB[7:4];
    rb = dif.D_rArB[3:0];
    p.stat  = dif.D_stat;
    p.icode = ic;
    p.ifun  = dif.D_opcode[3:0];
    p.valC  = dif.D_valC;
    p.srcA  = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra :
              (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    p.srcB  = (ic inside {4'h4, 4'h5, 4'h6}) ? rb :
              (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    p.dstE  = (ic inside {4'h2, 4'h3, 4'h6}) ? rb :
              (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    p.dstM  = (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    p.valA  = (ic inside {4'h7, 4'h8}) ? dif.D_valP : fwd_m(p.srcA);
    p.valB  = fwd_m(p.srcB);
    return p;
  endfunction

  task automatic check_e(input string pfx, input e_t x);
    check({pfx, ".stat"},  {62'h0, dif.E_stat},  {62'h0, x.stat});
    check({pfx, ".icode"}, {60'h0, dif.E_icode}, {60'h0, x.icode});
    check({pfx, ".ifun"},  {60'h0, dif.E_ifun},  {60'h0, x.ifun});
    check({pfx, ".valC"},  dif.E_valC, x.valC);
    check({pfx, ".valA"},  dif.E_valA, x.valA);
    check({pfx, ".valB"},  dif.E_valB, x.valB);
    check({pfx, ".dstE"},  {60'h0, dif.E_dstE},  {60'h0, x.dstE});
    check({pfx, ".dstM"},  {60'h0, dif.E_dstM},  {60'h0, x.dstM});
    check({pfx, ".srcA"},  {60'h0, dif.E_srcA},  {60'h0, x.srcA});
    check({pfx, ".srcB"},  {60'h0, dif.E_srcB},  {60'h0, x.srcB});
  endtask

  // Called at posedge+1 with inputs already set; ends at the next posedge+1.
  task automatic cycle(input string pfx);
    e_t p;
    #1;
    p = predict();
    check({pfx, ".d_srcA"}, {60'h0, dif.d_srcA}, {60'h0, p.srcA});
    check({pfx, ".d_srcB"}, {60'h0, dif.d_srcB}, {60'h0, p.srcB});
    ex = dif.E_bubble ? bubble_val() : p;
    @(posedge clk);
    #1;
    if (!reset) begin
      if (dif.W_dstE != 4'hF) rf_m[dif.W_dstE] = dif.W_valE;
      if (dif.W_dstM != 4'hF) rf_m[dif.W_dstM] = dif.W_valM;
    end
    check_e(pfx, ex);
  endtask

  task automatic idle_inputs();
    dif.D_stat = 2'b00;  dif.D_opcode = 8'h10; dif.D_rArB = 8'hFF;
    dif.D_valC = 64'h0;  dif.D_valP = 64'h0;   dif.E_bubble = 1'b0;
    dif.e_dstE = 4'hF;   dif.M_dstE = 4'hF;    dif.M_dstM = 4'hF;
    dif.W_dstE = 4'hF;   dif.W_dstM = 4'hF;
    dif.e_valE = 64'h0;  dif.M_valE = 64'h0;   dif.m_valM = 64'h0;
    dif.W_valE = 64'h0;  dif.W_valM = 64'h0;
  endtask

  function automatic logic [3:0] rand_id();
    if ($urandom_range(0, 2) == 0) return 4'hF;
    return 4'($urandom_range(0, 5));
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 15; i++) rf_m[i] = 64'h0;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_e("por", bubble_val());
    #2 reset = 1'b0;

    // writeback then read
    dif.W_dstE = 4'h3; dif.W_valE = 64'h55;
    cycle("wb_write");
    dif.W_dstE = 4'hF; dif.D_opcode = 8'h60; dif.D_rArB = 8'h37;
    cycle("wb_read");
    check("wb_valA", dif.E_valA, 64'h55);

    // forward priority
    dif.D_opcode = 8'h20; dif.D_rArB = 8'h2F;
    dif.e_dstE = 4'h2; dif.e_valE = 64'h11;
    dif.M_dstM = 4'h2; dif.m_valM = 64'h22;
    cycle("fwd_e");
    check("fwd_e_valA", dif.E_valA, 64'h11);
    dif.e_dstE = 4'hF;
    cycle("fwd_m");
    check("fwd_m_valA", dif.E_valA, 64'h22);
    idle_inputs();

    // call / pop
    dif.D_opcode = 8'h80; dif.D_rArB = 8'hFF; dif.D_valP = 64'h100;
    cycle("call");
    check("call_valA", dif.E_valA, 64'h100);
    check("call_srcB", {60'h0, dif.E_srcB}, 64'h4);
    check("call_dstE", {60'h0, dif.E_dstE}, 64'h4);
    dif.D_opcode = 8'hB0; dif.D_rArB = 8'h5F;
    cycle("pop");
    check("pop_srcA", {60'h0, dif.E_srcA}, 64'h4);
    check("pop_dstM", {60'h0, dif.E_dstM}, 64'h5);

    // bubble then release
    dif.D_opcode = 8'h61; dif.D_rArB = 8'h12; dif.E_bubble = 1'b1;
    cycle("bubble");
    check("bubble_icode", {60'h0, dif.E_icode}, 64'h1);
    check("bubble_dstE", {60'h0, dif.E_dstE}, 64'hF);
    dif.E_bubble = 1'b0;
    cycle("unbubble");
    check("unbubble_icode", {60'h0, dif.E_icode}, 64'h6);

    // dual write to one register: M port wins
    dif.D_opcode = 8'h10;
    dif.W_dstE = 4'h4; dif.W_valE = 64'h1; dif.W_dstM = 4'h4; dif.W_valM = 64'h2;
    cycle("dual_write");
    dif.W_dstE = 4'hF; dif.W_dstM = 4'hF;
    dif.D_opcode = 8'h60; dif.D_rArB = 8'h4F;
    cycle("dual_read");
    check("dual_valA", dif.E_valA, 64'h2);

    // non-AOK status passes through
    dif.D_stat = 2'b11;
    cycle("stat_ins");
    check("stat_ins_E", {62'h0, dif.E_stat}, 64'h3);
    dif.D_stat = 2'b00;

    // async reset between edges, with an in-flight write to reg 3
    #2;
    dif.W_dstE = 4'h3; dif.W_valE = 64'hDEAD;
    reset = 1'b1;
    #1;
    check_e("async_rst", bubble_val());
    @(posedge clk);
    #1;
    check_e("rst_hold", bubble_val());
    for (int i = 0; i < 15; i++) rf_m[i] = 64'h0;
    #2 reset = 1'b0;
    idle_inputs();
    dif.D_opcode = 8'h60; dif.D_rArB = 8'h3F;
    cycle("post_rst");
    check("post_rst_reg3", dif.E_valA, 64'h0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      dif.D_stat   = 2'($urandom_range(0, 3));
      dif.D_opcode = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 15))};
      dif.D_rArB   = {rand_id(), rand_id()};
      dif.D_valC   = {$urandom(), $urandom()};
      dif.D_valP   = {$urandom(), $urandom()};
      dif.E_bubble = ($urandom_range(0, 7) == 0);
      dif.e_dstE   = rand_id(); dif.e_valE = {$urandom(), $urandom()};
      dif.M_dstE   = rand_id(); dif.M_valE = {$urandom(), $urandom()};
      dif.M_dstM   = rand_id(); dif.m_valM = {$urandom(), $urandom()};
      dif.W_dstE   = rand_id(); dif.W_valE = {$urandom(), $urandom()};
      dif.W_dstM   = rand_id(); dif.W_valM = {$urandom(), $urandom()};
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
